// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the future receiver.
//   - parity mode codes as driven on the 'parity' config input
//   - TX frame state enumeration
package uart_pkg;

  // Code 1 is reserved and transmits without a parity bit, the same as NONE.
  localparam logic [1:0] UART_PARITY_NONE = 2'd0;
  localparam logic [1:0] UART_PARITY_EVEN = 2'd2;
  localparam logic [1:0] UART_PARITY_ODD  = 2'd3;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous word queue that feeds the UART transmitter.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   push   : write wdata (ignored while full)
//   pop    : drop the head word (ignored while empty)
//   wdata  : word to enqueue
//   rdata  : head word, valid while !empty
//   empty  : no words stored
//   full   : registered, set on the edge that brings level to DEPTH
//   level  : number of words stored, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [LW-1:0]               cnt_nxt;
  logic                        do_push;
  logic                        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    cnt_nxt = level;
    if (do_push && !do_pop)      cnt_nxt = level + LW'(1);
    else if (!do_push && do_pop) cnt_nxt = level - LW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= cnt_nxt;
      // Registered so in_ready never depends combinationally on pop.
      full  <= (cnt_nxt == LW'(DEPTH));
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_ext.sv
// uart_tx_ext: buffered UART transmitter with internal baud divider.
// Frame: start bit, 1..MAX_WIDTH data bits LSB first, optional parity,
// 1 or 2 stop bits; each bit lasts div+1 clocks.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low; drops queued and in-flight words
//   div      : bit period = div+1 clocks
//   parity   : 0 none, 1 reserved (none), 2 even, 3 odd
//   width    : data bits per frame (0 -> 1, above MAX_WIDTH -> MAX_WIDTH)
//   stop2    : 1 = two stop bits
//   in_valid : in_data valid
//   in_ready : queue can accept a word (registered)
//   in_data  : word to send, bits above width ignored
//   busy     : frame in progress or words waiting
//   level    : words waiting, excluding the one being shifted
//   out      : serial line, idle high
// Build option UART_TX_FIFO_EN: when defined, words wait in a FIFO_DEPTH
// entry queue; otherwise a single holding register is used.
// Config inputs are sampled only when a word is popped into the shifter.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter  int MAX_WIDTH  = 16,
  parameter  int DIV_WIDTH  = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int WW         = $clog2(MAX_WIDTH + 1),
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [1:0]           parity,
  input  logic [WW-1:0]        width,
  input  logic                 stop2,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_WIDTH-1:0] in_data,
  output logic                 busy,
  output logic [LW-1:0]        level,
  output logic                 out
);

  typedef struct packed {
    logic [DIV_WIDTH-1:0] baud_div;
    logic [1:0]           par_mode;
    logic [WW-1:0]        nbits;    // already clamped to 1..MAX_WIDTH
    logic                 two_stop;
  } frame_cfg_t;

  tx_state_e            state, state_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [WW-1:0]        bit_cnt, bit_nxt;
  logic [MAX_WIDTH-1:0] shift, shift_nxt;
  logic                 par_acc, par_nxt;
  frame_cfg_t           cfg, cfg_nxt;
  logic [WW-1:0]        eff_width;
  logic                 tick;
  logic                 par_en;
  logic                 frame_done;

  logic                 push;
  logic                 pop;
  logic                 q_valid;
  logic [MAX_WIDTH-1:0] q_data;

  assign push = in_valid && in_ready;

`ifdef UART_TX_FIFO_EN
  logic q_empty;
  logic q_full;

  uart_tx_fifo #(
    .WIDTH (MAX_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (q_data),
    .empty (q_empty),
    .full  (q_full),
    .level (level)
  );

  assign q_valid  = !q_empty;
  assign in_ready = !q_full;
`else
  logic                 hold_valid;
  logic [MAX_WIDTH-1:0] hold_data;

  // push needs !hold_valid and pop needs hold_valid, so they never coincide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign q_valid  = hold_valid;
  assign q_data   = hold_data;
  assign in_ready = !hold_valid;
  assign level    = LW'(hold_valid);
`endif

  assign busy   = (state != TX_IDLE) || (level != '0);
  assign tick   = (cnt == '0);
  assign par_en = (cfg.par_mode == UART_PARITY_EVEN) ||
                  (cfg.par_mode == UART_PARITY_ODD);

  always_comb begin
    eff_width = width;
    if (width == '0)                   eff_width = WW'(1);
    else if (width > WW'(MAX_WIDTH))   eff_width = WW'(MAX_WIDTH);
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    par_nxt    = par_acc;
    cfg_nxt    = cfg;
    frame_done = 1'b0;
    pop        = 1'b0;

    // Every bit state reloads the divisor on exit, which is the entry load
    // of whichever state follows.
    if (state != TX_IDLE) cnt_nxt = tick ? cfg.baud_div : cnt - DIV_WIDTH'(1);

    unique case (state)
      TX_IDLE:   state_nxt = TX_IDLE;
      TX_START:  if (tick) begin
                   state_nxt = TX_DATA;
                   bit_nxt   = '0;
                 end
      TX_DATA:   if (tick) begin
                   par_nxt   = par_acc ^ shift[0];
                   shift_nxt = shift >> 1;
                   bit_nxt   = bit_cnt + WW'(1);
                   if (bit_cnt == cfg.nbits - WW'(1))
                     state_nxt = par_en ? TX_PARITY : TX_STOP1;
                 end
      TX_PARITY: if (tick) state_nxt = TX_STOP1;
      TX_STOP1:  if (tick) begin
                   if (cfg.two_stop) state_nxt = TX_STOP2;
                   else              frame_done = 1'b1;
                 end
      TX_STOP2:  if (tick) frame_done = 1'b1;
      default:   state_nxt = TX_IDLE;
    endcase

    // A waiting word starts straight from the last stop clock, so
    // back-to-back frames have no idle bit between them.
    if (state == TX_IDLE || frame_done) begin
      if (q_valid) begin
        pop       = 1'b1;
        state_nxt = TX_START;
        cnt_nxt   = div;
        bit_nxt   = '0;
        par_nxt   = 1'b0;
        shift_nxt = q_data;
        cfg_nxt   = '{baud_div: div, par_mode: parity,
                      nbits: eff_width, two_stop: stop2};
      end else if (frame_done) begin
        state_nxt = TX_IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_acc <= 1'b0;
      cfg     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      par_acc <= par_nxt;
      cfg     <= cfg_nxt;
    end
  end

  // Decoded from registers only; reset forces IDLE and so the line high.
  always_comb begin
    out = 1'b1;
    unique case (state)
      TX_START:  out = 1'b0;
      TX_DATA:   out = shift[0];
      TX_PARITY: out = par_acc ^ (cfg.par_mode == UART_PARITY_ODD);
      default:   out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext: randomized self-checking bench for uart_tx_ext.
// The line is sampled every falling clock edge; expected waveforms are built
// from frame descriptions (start, data LSB first, parity, stops, each bit
// repeated div+1 times) and compared frame by frame.
module tb_uart_tx_ext;
  localparam int MW = 16;
  localparam int DW = 16;
  localparam int FD = 8;
`ifdef UART_TX_FIFO_EN
  localparam int QD = FD;
`else
  localparam int QD = 1;
`endif

  logic          clock = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] cfg_div = '0;
  logic [1:0]    cfg_par = '0;
  logic [4:0]    cfg_width = 5'd8;
  logic          cfg_stop2 = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_data = '0;
  logic          busy;
  logic [3:0]    level;
  logic          tx;

  uart_tx_ext #(.MAX_WIDTH(MW), .DIV_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(rst_n), .div(cfg_div), .parity(cfg_par),
    .width(cfg_width), .stop2(cfg_stop2), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .busy(busy), .level(level),
    .out(tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [MW-1:0] data;
    int            div;
    int            par;
    int            width;
    bit            stop2;
  } frame_t;

  int     total = 0;
  int     bad = 0;
  logic   rec = 1'b0;
  logic   line_q[$];
  logic   busy_q[$];
  int     rdy_err = 0;
  int     lvl_max = 0;
  frame_t exp_q[$];

  always @(negedge clock) begin
    if (rec) begin
      line_q.push_back(tx);
      busy_q.push_back(busy);
      if (in_ready !== (level != 4'(QD))) rdy_err++;
      if (int'(level) > lvl_max) lvl_max = int'(level);
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [MW-1:0] d, input int dv, input int p,
                                input int w, input bit s2);
    frame_t f;
    f.data = d; f.div = dv; f.par = p; f.width = w; f.stop2 = s2;
    return f;
  endfunction

  // Expected line waveform of one frame; returns its length in clocks.
  function automatic int frame_wave(input frame_t f, output logic [255:0] v);
    int   w;
    int   n;
    logic b[$];
    w = (f.width == 0) ? 1 : ((f.width > MW) ? MW : f.width);
    b.push_back(1'b0);
    for (int i = 0; i < w; i++) b.push_back(f.data[i]);
    if (f.par >= 2)
      b.push_back((($countones(32'(f.data) & ((32'd1 << w) - 1)) % 2) == 1) != (f.par == 3));
    b.push_back(1'b1);
    if (f.stop2) b.push_back(1'b1);
    v = '0;
    n = 0;
    foreach (b[i]) for (int k = 0; k <= f.div; k++) begin v[n] = b[i]; n++; end
    return n;
  endfunction

  function automatic logic samp(input int i);
    return (i < line_q.size()) ? line_q[i] : 1'bx;
  endfunction

  function automatic logic bsamp(input int i);
    return (i < busy_q.size()) ? busy_q[i] : 1'bx;
  endfunction

  task automatic push_word(input logic [MW-1:0] d);
    int n;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 2000) begin @(negedge clock); n++; end
    if (!in_ready) chk("push_timeout", in_ready, 1'b1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 20000) begin @(negedge clock); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic check_stream(input string tag);
    int          s;
    int          pos;
    int          n;
    int          bl;
    logic [255:0] ev;
    logic [255:0] gv;
    s = -1;
    for (int i = 0; i < line_q.size(); i++)
      if (line_q[i] === 1'b0) begin s = i; break; end
    chk($sformatf("%s_start", tag), s >= 0, 1'b1);
    if (s < 0) return;
    pos = s;
    bl  = 0;
    foreach (exp_q[f]) begin
      n  = frame_wave(exp_q[f], ev);
      gv = '0;
      for (int k = 0; k < n; k++) begin
        gv[k] = samp(pos + k);
        if (bsamp(pos + k) !== 1'b1) bl++;
      end
      chk($sformatf("%s_f%0d", tag, f), gv, ev);
      pos += n;
    end
    chk($sformatf("%s_busy", tag), bl, 0);
    chk($sformatf("%s_end_out", tag), samp(pos), 1'b1);
    chk($sformatf("%s_end_busy", tag), bsamp(pos), 1'b0);
  endtask

  task automatic start_rec();
    line_q.delete();
    busy_q.delete();
    rdy_err = 0;
    lvl_max = 0;
    @(negedge clock);
    rec = 1'b1;
  endtask

  task automatic stop_rec();
    repeat (3) @(negedge clock);
    rec = 1'b0;
  endtask

  task automatic run_batch(input string tag);
    cfg_div   = DW'(exp_q[0].div);
    cfg_par   = 2'(exp_q[0].par);
    cfg_width = 5'(exp_q[0].width);
    cfg_stop2 = exp_q[0].stop2;
    start_rec();
    foreach (exp_q[i]) push_word(exp_q[i].data);
    wait_idle();
    stop_rec();
    check_stream(tag);
  endtask

  initial begin
    int zeros;
    int bsy;
    int nf;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_out", tx, 1'b1);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_level", level, 4'd0);
    rst_n = 1'b1;

    // 8N1, div=3, 0x55: first-word latency then the full waveform.
    exp_q = {mk(16'h55, 3, 0, 8, 1'b0)};
    cfg_div = 3; cfg_par = 0; cfg_width = 8; cfg_stop2 = 0;
    start_rec();
    push_word(16'h0055);
    @(negedge clock);
    chk("lat_out_hi", tx, 1'b1);
    chk("lat_level1", level, 4'd1);
    chk("lat_busy", busy, 1'b1);
    @(negedge clock);
    chk("lat_out_lo", tx, 1'b0);
    chk("lat_level0", level, 4'd0);
    wait_idle();
    stop_rec();
    check_stream("8n1");

    exp_q = {mk(16'h0003, 0, 2, 7, 1'b1)};
    run_batch("7e2");
    exp_q = {mk(16'h0003, 0, 3, 7, 1'b1)};
    run_batch("7o2");

    // Back-to-back burst deeper than the queue.
    exp_q.delete();
    for (int i = 0; i < FD + 2; i++) exp_q.push_back(mk(MW'($urandom), 1, 0, 8, 1'b0));
    run_batch("b2b");
    chk("b2b_lvlmax", lvl_max, QD);
    chk("b2b_rdy", rdy_err, 0);

    // Width clamping.
    exp_q = {mk(16'h0001, 1, 0, 0, 1'b0)};
    run_batch("w0");
    exp_q = {mk(MW'($urandom), 1, 3, 17, 1'b1)};
    run_batch("w17");
    exp_q = {mk(MW'($urandom), 0, 2, 31, 1'b0)};
    run_batch("w31");

    // Divisor change while frame 1 shifts only affects frame 2.
    exp_q = {mk(MW'($urandom), 2, 0, 8, 1'b0), mk(MW'($urandom), 5, 0, 8, 1'b0)};
    cfg_div = 2; cfg_par = 0; cfg_width = 8; cfg_stop2 = 0;
    start_rec();
    push_word(exp_q[0].data);
    push_word(exp_q[1].data);
    repeat (5) @(negedge clock);
    cfg_div = 5;
    wait_idle();
    stop_rec();
    check_stream("divchg");

    // Reset in the data bits of frame 2 of 3.
    cfg_div = 1; cfg_par = 0; cfg_width = 8; cfg_stop2 = 0;
    fork
      begin push_word(16'h0); push_word(16'h0); push_word(16'h0); end
      begin repeat (28) @(negedge clock); end
    join
    chk("mid_out_lo", tx, 1'b0);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_out", tx, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_level", level, 4'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    zeros = 0;
    bsy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) zeros++;
      if (busy !== 1'b0) bsy++;
    end
    chk("post_rst_zeros", zeros, 0);
    chk("post_rst_busy", bsy, 0);
    chk("post_rst_level", level, 4'd0);
    chk("post_rst_rdy", in_ready, 1'b1);

    // Randomized batches, config fixed per batch.
    for (int b = 0; b < 8; b++) begin
      int dv, p, w;
      bit s2;
      dv = $urandom_range(0, 4);
      p  = $urandom_range(0, 3);
      w  = $urandom_range(0, 20);
      s2 = 1'($urandom_range(0, 1));
      nf = $urandom_range(1, 4);
      exp_q.delete();
      for (int i = 0; i < nf; i++) exp_q.push_back(mk(MW'($urandom), dv, p, w, s2));
      run_batch($sformatf("rnd%0d", b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
